// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (800x600@72), RGB colour codes and timing helpers.
package vga_pkg;

    localparam int unsigned DEF_H_VIS  = 800;
    localparam int unsigned DEF_H_FP   = 56;
    localparam int unsigned DEF_H_SYNC = 120;
    localparam int unsigned DEF_H_BP   = 64;
    localparam int unsigned DEF_V_VIS  = 600;
    localparam int unsigned DEF_V_FP   = 37;
    localparam int unsigned DEF_V_SYNC = 6;
    localparam int unsigned DEF_V_BP   = 23;

    localparam int unsigned RGB_W = 3;

    // 3-bit RGB, red in the MSB
    localparam logic [RGB_W-1:0] C_BLACK   = 3'b000;
    localparam logic [RGB_W-1:0] C_RED     = 3'b100;
    localparam logic [RGB_W-1:0] C_GREEN   = 3'b010;
    localparam logic [RGB_W-1:0] C_YELLOW  = 3'b110;
    localparam logic [RGB_W-1:0] C_BLUE    = 3'b001;
    localparam logic [RGB_W-1:0] C_MAGENTA = 3'b101;
    localparam logic [RGB_W-1:0] C_CYAN    = 3'b011;
    localparam logic [RGB_W-1:0] C_WHITE   = 3'b111;

    function automatic int unsigned total(input int unsigned vis, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pixel/colour logic.
interface vga_timing_gen_if #(
    parameter int unsigned CNT_W   = 11,
    parameter int unsigned FRAME_W = 16
);
    logic               pix_en_out;
    logic               hsync_out;
    logic               vsync_out;
    logic               blank_out;
    logic [CNT_W-1:0]   x_coord_out;
    logic [CNT_W-1:0]   y_coord_out;
    logic               line_start_out;
    logic               frame_start_out;
    logic [FRAME_W-1:0] frame_cnt_out;

    modport master (
        output pix_en_out, hsync_out, vsync_out, blank_out, x_coord_out, y_coord_out,
               line_start_out, frame_start_out, frame_cnt_out
    );

    modport slave (
        input  pix_en_out, hsync_out, vsync_out, blank_out, x_coord_out, y_coord_out,
               line_start_out, frame_start_out, frame_cnt_out
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus combinational sync/visible/coordinate decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned VIS   = DEF_H_VIS,
    parameter int unsigned FP    = DEF_H_FP,
    parameter int unsigned SYNC  = DEF_H_SYNC,
    parameter int unsigned BP    = DEF_H_BP,
    parameter bit          POL   = 1'b0,
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             step_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_c_o,
    output logic             sync_c_o,
    output logic             vis_c_o,
    output logic [CNT_W-1:0] coord_c_o
);
    localparam int unsigned      TOTAL   = total(VIS, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] VIS_N   = CNT_W'(VIS);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VIS + FP);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VIS + FP + SYNC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sync_act;

    always_comb begin
        cnt_d = cnt_q;
        if (step_i) begin
            cnt_d = wrap_c_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Wrap is qualified by step so the next axis / frame counter can chain directly.
    assign wrap_c_o  = step_i && (cnt_q == LAST);
    assign sync_act  = (cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI);
    assign sync_c_o  = sync_act ? POL : !POL;
    assign vis_c_o   = (cnt_q < VIS_N);
    assign coord_c_o = vis_c_o ? cnt_q : '1;
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Single-clock VGA raster generator: pixel divider, chained axis counters, frame counter, registered decode.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS   = DEF_H_VIS,
    parameter int unsigned H_FP    = DEF_H_FP,
    parameter int unsigned H_SYNC  = DEF_H_SYNC,
    parameter int unsigned H_BP    = DEF_H_BP,
    parameter int unsigned V_VIS   = DEF_V_VIS,
    parameter int unsigned V_FP    = DEF_V_FP,
    parameter int unsigned V_SYNC  = DEF_V_SYNC,
    parameter int unsigned V_BP    = DEF_V_BP,
    parameter bit          H_POL   = 1'b0,
    parameter bit          V_POL   = 1'b0,
    parameter int unsigned PIX_DIV = 1,
    parameter int unsigned CNT_W   = 11,
    parameter int unsigned FRAME_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    vga_timing_gen_if.master vga
);
    localparam int unsigned      DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               pix_en;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

    logic [CNT_W-1:0]   h_cnt, v_cnt, h_coord, v_coord;
    logic               h_wrap, v_wrap, h_sync, v_sync, h_vis, v_vis, v_step;

    logic               pix_en_q;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               blank_q, blank_d;
    logic [CNT_W-1:0]   x_q, x_d;
    logic [CNT_W-1:0]   y_q, y_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] frame_out_q, frame_out_d;

    assign pix_en = (div_cnt_q == DIV_LAST);
    assign v_step = h_wrap;

    vga_axis_counter #(
        .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk_i(sys_clk), .rst_i(sys_rst), .step_i(pix_en), .cnt_o(h_cnt),
        .wrap_c_o(h_wrap), .sync_c_o(h_sync), .vis_c_o(h_vis), .coord_c_o(h_coord)
    );

    vga_axis_counter #(
        .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk_i(sys_clk), .rst_i(sys_rst), .step_i(v_step), .cnt_o(v_cnt),
        .wrap_c_o(v_wrap), .sync_c_o(v_sync), .vis_c_o(v_vis), .coord_c_o(v_coord)
    );

    always_comb begin
        div_cnt_d   = pix_en ? '0 : div_cnt_q + DIV_W'(1);
        frame_cnt_d = v_wrap ? frame_cnt_q + FRAME_W'(1) : frame_cnt_q;
    end

    // Decode of the pre-increment counters; registers hold between pixel enables.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        blank_d       = blank_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        frame_out_d   = frame_out_q;
        if (pix_en) begin
            hsync_d       = h_sync;
            vsync_d       = v_sync;
            blank_d       = !(h_vis && v_vis);
            x_d           = h_coord;
            y_d           = v_coord;
            line_start_d  = (h_cnt == '0);
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
            frame_out_d   = frame_cnt_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            pix_en_q      <= 1'b0;
            hsync_q       <= !H_POL;
            vsync_q       <= !V_POL;
            blank_q       <= 1'b1;
            x_q           <= '1;
            y_q           <= '1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_out_q   <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            pix_en_q      <= pix_en;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_out_q   <= frame_out_d;
        end
    end

    assign vga.pix_en_out      = pix_en_q;
    assign vga.hsync_out       = hsync_q;
    assign vga.vsync_out       = vsync_q;
    assign vga.blank_out       = blank_q;
    assign vga.x_coord_out     = x_q;
    assign vga.y_coord_out     = y_q;
    assign vga.line_start_out  = line_start_q;
    assign vga.frame_start_out = frame_start_q;
    assign vga.frame_cnt_out   = frame_out_q;

endmodule
